// File: rtl/chunked_addsub_unit.sv
// chunked_addsub_unit: multi-cycle adder/subtractor that processes CHUNK bits
// per clock, LSB slice first, and registers Sum/CO/OVF/Done at the end.
// Optional build macro: ADDER_SAT_EN -- clamps Sum to the signed limit on overflow.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for a Run rising edge; LoadB loads B from SW
// S_COMPUTE | one CHUNK slice per clock; LoadB and Run edges are ignored
// S_DONE    | result valid and Done held; LoadB and a new start are accepted
module chunked_addsub_unit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadB,
    input  logic             Run,
    input  logic             Sub,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Sum,
    output logic             CO,
    output logic             OVF,
    output logic             Busy,
    output logic             Done
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH < 2) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
            $error("chunked_addsub_unit: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   a_sh;      // A, shifted right one slice per clock
    logic [WIDTH-1:0]   b_sh;      // B or ~B, shifted alongside A
    logic [WIDTH-1:0]   res;       // result assembled from the top down
    logic               carry;
    logic [CNT_W-1:0]   cnt;       // slices remaining after the current one
    logic               run_q;

    logic [CHUNK:0]     slice_sum;
    logic [WIDTH-1:0]   res_next;
    logic [WIDTH-1:0]   sum_final;
    logic               msb_cin;
    logic               ovf_next;

    // Slice adder, result assembly and overflow from the slice holding the MSB
    always_comb begin
        slice_sum = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry};
        res_next  = (res >> CHUNK) | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        // carry into the MSB recovered from the MSB's sum and operand bits
        msb_cin   = slice_sum[CHUNK-1] ^ a_sh[CHUNK-1] ^ b_sh[CHUNK-1];
        ovf_next  = msb_cin ^ slice_sum[CHUNK];
`ifdef ADDER_SAT_EN
        // a wrapped negative result means positive overflow, and vice versa
        if (ovf_next) begin
            sum_final = {~res_next[WIDTH-1], {(WIDTH-1){res_next[WIDTH-1]}}};
        end else begin
            sum_final = res_next;
        end
`else
        sum_final = res_next;
`endif
    end

    // Sequencer: operand capture, slice iteration and result registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            Sum   <= '0;
            CO    <= 1'b0;
            OVF   <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            b_reg <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            run_q <= 1'b1;     // Run held through reset must drop before a start
        end else begin
            run_q <= Run;
            case (state)
                S_IDLE, S_DONE: begin
                    if (LoadB) begin
                        b_reg <= SW;
                    end
                    if (Run && !run_q) begin
                        a_sh  <= SW;
                        b_sh  <= Sub ? ~b_reg : b_reg;   // old B when LoadB coincides
                        carry <= Sub;
                        cnt   <= CNT_W'(N - 1);
                        res   <= '0;
                        Busy  <= 1'b1;
                        Done  <= 1'b0;
                        state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    a_sh  <= a_sh >> CHUNK;
                    b_sh  <= b_sh >> CHUNK;
                    carry <= slice_sum[CHUNK];
                    res   <= res_next;
                    if (cnt == '0) begin
                        Sum   <= sum_final;
                        CO    <= slice_sum[CHUNK];
                        OVF   <= ovf_next;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_addsub_unit.sv
// Testbench for chunked_addsub_unit (WIDTH=16, CHUNK=4): directed scenarios
// plus randomized operations against a signed/unsigned arithmetic model.
module tb_chunked_addsub_unit;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic             Clk;
    logic             Reset;
    logic             LoadB;
    logic             Run;
    logic             Sub;
    logic [WIDTH-1:0] SW;
    logic [WIDTH-1:0] Sum;
    logic             CO;
    logic             OVF;
    logic             Busy;
    logic             Done;

    chunked_addsub_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .LoadB (LoadB),
        .Run   (Run),
        .Sub   (Sub),
        .SW    (SW),
        .Sum   (Sum),
        .CO    (CO),
        .OVF   (OVF),
        .Busy  (Busy),
        .Done  (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] b_model;
    logic [WIDTH-1:0] last_sum;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_co;
    logic             exp_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: exact integer arithmetic, then wrap / saturate
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
        int sa, sb, exact_s;
        int ua, ub, exact_u;
        int lim;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = int'(a);
        ub  = int'(b);
        lim = 1 << (WIDTH - 1);
        exact_s = sub ? (sa - sb) : (sa + sb);
        exact_u = sub ? (ua - ub) : (ua + ub);
        exp_sum = exact_u[WIDTH-1:0];
        exp_co  = sub ? (ua >= ub) : (exact_u >= (1 << WIDTH));
        exp_ovf = (exact_s >= lim) || (exact_s < -lim);
`ifdef ADDER_SAT_EN
        if (exp_ovf) begin
            exp_sum = (exact_s > 0) ? WIDTH'(lim - 1) : WIDTH'(lim);
        end
`endif
    endtask

    task automatic load_b(input logic [WIDTH-1:0] b);
        LoadB = 1'b1;
        SW    = b;
        tick();
        LoadB = 1'b0;
        b_model = b;
    endtask

    // Start an operation and follow it to Done; optionally disturb it mid-flight
    task automatic run_op(input logic [WIDTH-1:0] a, input logic sub, input logic load_same,
                          input logic disturb, input string tag);
        logic [WIDTH-1:0] held;
        logic [WIDTH-1:0] b_old;
        int cyc;
        held  = last_sum;
        b_old = b_model;
        SW    = a;
        Sub   = sub;
        Run   = 1'b1;
        LoadB = load_same;
        tick();
        Run   = 1'b0;
        LoadB = 1'b0;
        if (load_same) b_model = a;
        model(a, b_old, sub);
        check({tag, "_busy_start"}, Busy, 1'b1);
        check({tag, "_done_clr"}, Done, 1'b0);
        SW  = WIDTH'($urandom);
        Sub = ~sub;
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (disturb && cyc == 1) begin
                LoadB = 1'b1;
                SW    = 16'h1234;
                Run   = 1'b1;
            end
            tick();
            LoadB = 1'b0;
            Run   = 1'b0;
            if (Done) break;
            check({tag, "_hold"}, Sum, held);
        end
        check({tag, "_latency"}, cyc, N);
        check({tag, "_sum"}, Sum, exp_sum);
        check({tag, "_co"}, CO, exp_co);
        check({tag, "_ovf"}, OVF, exp_ovf);
        check({tag, "_busy_end"}, Busy, 1'b0);
        last_sum = exp_sum;
    endtask

    initial begin
        Reset = 1'b1;
        LoadB = 1'b0;
        Run   = 1'b0;
        Sub   = 1'b0;
        SW    = '0;
        b_model  = '0;
        last_sum = '0;
        tick();
        tick();
        check("rst_sum", Sum, 0);
        check("rst_flags", {CO, OVF, Busy, Done}, 4'b0000);
        Reset = 1'b0;
        tick();

        // 1. FFFE + 0001
        load_b(16'hFFFE);
        run_op(16'h0001, 1'b0, 1'b0, 1'b0, "t1");
        check("t1_const", {Sum, CO, OVF}, {16'hFFFF, 2'b00});

        // 2. 0385 + 0ECE, then back-to-back start from DONE
        load_b(16'h0ECE);
        run_op(16'h0385, 1'b0, 1'b0, 1'b0, "t2");
        check("t2_const", {Sum, CO, OVF}, {16'h1253, 2'b00});
        run_op(16'h1111, 1'b1, 1'b0, 1'b0, "t2b");

        // 3. FFFF + FFFF
        load_b(16'hFFFF);
        run_op(16'hFFFF, 1'b0, 1'b0, 1'b0, "t3");
        check("t3_const", {Sum, CO, OVF}, {16'hFFFE, 2'b10});

        // 4. 8000 - 0001 overflows
        load_b(16'h0001);
        run_op(16'h8000, 1'b1, 1'b0, 1'b0, "t4");
`ifdef ADDER_SAT_EN
        check("t4_const", {Sum, CO, OVF}, {16'h8000, 2'b11});
`else
        check("t4_const", {Sum, CO, OVF}, {16'h7FFF, 2'b11});
`endif

        // 6. LoadB and Run edge during COMPUTE are ignored
        load_b(16'h0100);
        run_op(16'h0023, 1'b0, 1'b0, 1'b1, "t6");
        check("t6_const", Sum, 16'h0123);
        run_op(16'h0001, 1'b0, 1'b0, 1'b0, "t6_bkeep");
        check("t6_bkeep_const", Sum, 16'h0101);

        // LoadB on the start edge: op uses old B, new B used next time
        run_op(16'h0200, 1'b0, 1'b1, 1'b0, "same_edge");
        check("same_edge_const", Sum, 16'h0300);
        run_op(16'h0001, 1'b0, 1'b0, 1'b0, "same_edge_newb");
        check("same_edge_newb_const", Sum, 16'h0201);

        // 5. Reset two clocks after start, Run held high through it
        load_b(16'h1111);
        SW  = 16'h2222;
        Sub = 1'b0;
        Run = 1'b1;
        tick();
        tick();
        tick();
        Reset = 1'b1;
        #1;
        check("t5_sum", Sum, 0);
        check("t5_flags", {CO, OVF, Busy, Done}, 4'b0000);
        tick();
        Reset = 1'b0;
        b_model  = '0;
        last_sum = '0;
        tick();
        tick();
        tick();
        check("t5_no_start", {Busy, Done}, 2'b00);
        Run = 1'b0;
        tick();
        run_op(16'h0005, 1'b0, 1'b0, 1'b0, "t5_restart");

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) load_b(WIDTH'($urandom));
            run_op(WIDTH'($urandom), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
